// File: rtl/rf_writeback.sv
// Register-file write-port arbiter: pipeline writeback has priority, divider results queue in a FIFO.
// Optional macro RF_WB_BYPASS_EN adds fwd1/fwd2 forwarding ports and early busy release.
module rf_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        div_issue,
  input  logic [4:0]  div_issue_rd,
  input  logic        div_valid,
  input  logic [4:0]  div_rd,
  input  logic [31:0] div_data,
  output logic        div_ready,
  input  logic [4:0]  src1_addr,
  input  logic [4:0]  src2_addr,
  output logic        src1_busy,
  output logic        src2_busy,
`ifdef RF_WB_BYPASS_EN
  output logic        fwd1_valid,
  output logic        fwd2_valid,
  output logic [31:0] fwd1_data,
  output logic [31:0] fwd2_data,
`endif
  output logic        stall_req,
  output logic        wr_en,
  output logic [4:0]  dest_addr,
  output logic [31:0] wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

  // Divider handshake: a result transfers on the rising edge where div_valid && div_ready;
  // the divider holds div_rd/div_data stable while div_valid is high and div_ready is low.

  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [31:0]   r_sb;
  logic [CW-1:0] r_starve;

  logic [AW:0]   w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_wb_take;
  logic          w_pop;
  logic          w_push;
  logic [4:0]    w_head_rd;
  logic [31:0]   w_head_data;
  logic [31:0]   w_sb_next;
  logic [CW-1:0] w_starve_next;
  logic          w_src1_pend;
  logic          w_src2_pend;

  assign w_count     = r_wptr - r_rptr;
  assign w_empty     = (r_wptr == r_rptr);
  assign w_full      = (w_count == FULL_CNT);
  assign w_head_rd   = r_fifo_rd[r_rptr[AW-1:0]];
  assign w_head_data = r_fifo_data[r_rptr[AW-1:0]];

  // x0 pipeline writes never claim the port, so the FIFO may drain underneath them.
  assign w_wb_take = nrst && wb_valid && (wb_rd != 5'd0);
  assign w_pop     = nrst && !w_wb_take && !w_empty;
  assign div_ready = !w_full;
  assign w_push    = nrst && div_valid && div_ready && (div_rd != 5'd0);

  always_comb begin
    wr_en     = 1'b0;
    dest_addr = 5'd0;
    wr_data   = 32'd0;
    if (w_wb_take) begin
      wr_en     = 1'b1;
      dest_addr = wb_rd;
      wr_data   = wb_data;
    end else if (w_pop) begin
      wr_en     = 1'b1;
      dest_addr = w_head_rd;
      wr_data   = w_head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr[AW-1:0]]   <= div_rd;
      r_fifo_data[r_wptr[AW-1:0]] <= div_data;
    end
  end

  // Clear first, then set, so a same-cycle reissue to the draining register stays pending.
  always_comb begin
    w_sb_next = r_sb;
    if (w_pop) w_sb_next[w_head_rd] = 1'b0;
    if (div_issue && (div_issue_rd != 5'd0)) w_sb_next[div_issue_rd] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) r_sb <= '0;
    else       r_sb <= w_sb_next;
  end

  always_comb begin
    w_starve_next = r_starve;
    if (w_empty || w_pop)
      w_starve_next = '0;
    else if (w_wb_take && (r_starve != LIMIT_CNT))
      w_starve_next = r_starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) r_starve <= '0;
    else       r_starve <= w_starve_next;
  end

  assign stall_req = nrst && (r_starve == LIMIT_CNT);

  assign w_src1_pend = nrst && r_sb[src1_addr];
  assign w_src2_pend = nrst && r_sb[src2_addr];

`ifdef RF_WB_BYPASS_EN
  assign src1_busy  = w_src1_pend && !(w_pop && (w_head_rd == src1_addr));
  assign src2_busy  = w_src2_pend && !(w_pop && (w_head_rd == src2_addr));
  assign fwd1_valid = wr_en && (dest_addr == src1_addr) && (src1_addr != 5'd0);
  assign fwd2_valid = wr_en && (dest_addr == src2_addr) && (src2_addr != 5'd0);
  assign fwd1_data  = wr_data;
  assign fwd2_data  = wr_data;
`else
  assign src1_busy  = w_src1_pend;
  assign src2_busy  = w_src2_pend;
`endif

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: reset, idle drain, priority/starvation, back-pressure, x0, scoreboard race.
module tb_rf_writeback;

  logic        clk;
  logic        nrst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        div_issue;
  logic [4:0]  div_issue_rd;
  logic        div_valid;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        div_ready;
  logic [4:0]  src1_addr;
  logic [4:0]  src2_addr;
  logic        src1_busy;
  logic        src2_busy;
  logic        stall_req;
  logic        wr_en;
  logic [4:0]  dest_addr;
  logic [31:0] wr_data;
`ifdef RF_WB_BYPASS_EN
  logic        fwd1_valid;
  logic        fwd2_valid;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [36:0] exp_q[$];

  rf_writeback #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .nrst(nrst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .div_issue(div_issue), .div_issue_rd(div_issue_rd),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data),
    .div_ready(div_ready),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .src1_busy(src1_busy), .src2_busy(src2_busy),
`ifdef RF_WB_BYPASS_EN
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
`endif
    .stall_req(stall_req),
    .wr_en(wr_en), .dest_addr(dest_addr), .wr_data(wr_data)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard: the oldest expected divider write must be on the port now
  task automatic expect_div_write(input string tag);
    logic [36:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_wr_en"}, {63'd0, wr_en}, 64'd1);
      chk({tag, "_addr_data"}, {27'd0, dest_addr, wr_data}, {27'd0, e});
    end
  endtask

  initial begin
    nrst = 1'b0; wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h5555_5555;
    div_issue = 1'b0; div_issue_rd = 5'd0;
    div_valid = 1'b0; div_rd = 5'd0; div_data = 32'd0;
    src1_addr = 5'd7; src2_addr = 5'd7;

    // reset with a pending pipeline writeback
    tick(); tick();
    chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("rst_dest", {59'd0, dest_addr}, 64'd0);
    chk("rst_data", {32'd0, wr_data}, 64'd0);
    chk("rst_ready", {63'd0, div_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall_req}, 64'd0);
    chk("rst_busy", {62'd0, src1_busy, src2_busy}, 64'd0);
    nrst = 1'b1; wb_valid = 1'b0;
    tick();

    // idle drain
    div_issue = 1'b1; div_issue_rd = 5'd7;
    settle();
    chk("drain_busy_pre", {63'd0, src1_busy}, 64'd0);
    tick();
    div_issue = 1'b0;
    settle();
    chk("drain_busy_issue", {62'd0, src1_busy, src2_busy}, 64'd3);
    for (int i = 0; i < 9; i++) tick();
    chk("drain_busy_hold", {63'd0, src1_busy}, 64'd1);
    div_valid = 1'b1; div_rd = 5'd7; div_data = 32'h0000_002A;
    settle();
    chk("drain_no_same_cycle", {63'd0, wr_en}, 64'd0);
    exp_q.push_back({5'd7, 32'h0000_002A});
    tick();
    div_valid = 1'b0;
    settle();
    expect_div_write("drain");
    chk("drain_busy_wr_cycle", {63'd0, src1_busy}, {63'd0, !BYP});
`ifdef RF_WB_BYPASS_EN
    chk("drain_fwd1", {31'd0, fwd1_valid, fwd1_data}, {31'd0, 1'b1, 32'h2A});
`endif
    tick();
    chk("drain_busy_after", {63'd0, src1_busy}, 64'd0);
    chk("drain_idle", {63'd0, wr_en}, 64'd0);

    // priority and starvation
    div_issue = 1'b1; div_issue_rd = 5'd3; src1_addr = 5'd3;
    tick();
    div_issue = 1'b0;
    div_valid = 1'b1; div_rd = 5'd3; div_data = 32'h0000_0033;
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h0000_0099;
    tick();
    div_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk($sformatf("starve_pipe%0d", i), {27'd0, dest_addr, wr_data}, {27'd0, 5'd9, 32'h99});
      chk($sformatf("starve_nostall%0d", i), {63'd0, stall_req}, 64'd0);
      tick();
    end
    chk("starve_stall5", {63'd0, stall_req}, 64'd1);
    chk("starve_pipe5", {59'd0, dest_addr}, 64'd9);
    exp_q.push_back({5'd3, 32'h0000_0033});
    tick();
    wb_valid = 1'b0;
    settle();
    expect_div_write("starve_drain");
    chk("starve_busy3", {63'd0, src1_busy}, {63'd0, !BYP});
    tick();
    chk("starve_cleared", {63'd0, stall_req}, 64'd0);
    chk("starve_busy3_after", {63'd0, src1_busy}, 64'd0);

    // full back-pressure
    wb_valid = 1'b1; wb_rd = 5'd9;
    div_valid = 1'b1; div_rd = 5'd10; div_data = 32'h0000_00A0;
    settle();
    chk("full_ready0", {63'd0, div_ready}, 64'd1);
    tick();
    div_rd = 5'd11; div_data = 32'h0000_00B0;
    settle();
    chk("full_ready1", {63'd0, div_ready}, 64'd1);
    tick();
    div_rd = 5'd12; div_data = 32'h0000_00C0;
    settle();
    chk("full_ready_full", {63'd0, div_ready}, 64'd0);
    tick();
    wb_valid = 1'b0;
    exp_q.push_back({5'd10, 32'h0000_00A0});
    settle();
    expect_div_write("full_pop1");
    chk("full_ready_on_pop", {63'd0, div_ready}, 64'd0);
    tick();
    wb_valid = 1'b1;
    settle();
    chk("full_ready_after_pop", {63'd0, div_ready}, 64'd1);
    chk("full_pipe", {59'd0, dest_addr}, 64'd9);
    tick();
    div_valid = 1'b0; wb_valid = 1'b0;
    exp_q.push_back({5'd11, 32'h0000_00B0});
    exp_q.push_back({5'd12, 32'h0000_00C0});
    settle();
    expect_div_write("full_pop2");
    tick();
    expect_div_write("full_pop3");
    tick();
    chk("full_empty", {63'd0, wr_en}, 64'd0);

    // x0 handling
    wb_valid = 1'b1; wb_rd = 5'd9;
    div_valid = 1'b1; div_rd = 5'd13; div_data = 32'h0000_00D0;
    tick();
    wb_rd = 5'd0; wb_data = 32'h0000_0055;
    div_rd = 5'd0; div_data = 32'h0000_00EE;
    exp_q.push_back({5'd13, 32'h0000_00D0});
    settle();
    expect_div_write("x0_head");
    chk("x0_ready", {63'd0, div_ready}, 64'd1);
    tick();
    div_valid = 1'b0;
    settle();
    chk("x0_discarded", {63'd0, wr_en}, 64'd0);
    tick();
    wb_valid = 1'b0;
    settle();
    chk("x0_still_idle", {63'd0, wr_en}, 64'd0);

    // scoreboard race
    src1_addr = 5'd4; src2_addr = 5'd7;
    div_issue = 1'b1; div_issue_rd = 5'd4;
    wb_valid = 1'b1; wb_rd = 5'd9;
    tick();
    div_issue = 1'b0;
    div_valid = 1'b1; div_rd = 5'd4; div_data = 32'h0000_0044;
    tick();
    div_valid = 1'b0; wb_valid = 1'b0;
    div_issue = 1'b1; div_issue_rd = 5'd4;
    exp_q.push_back({5'd4, 32'h0000_0044});
    settle();
    expect_div_write("race");
    chk("race_busy_wr", {63'd0, src1_busy}, {63'd0, !BYP});
    tick();
    div_issue = 1'b0;
    settle();
    chk("race_set_wins", {63'd0, src1_busy}, 64'd1);
    chk("race_other_clear", {63'd0, src2_busy}, 64'd0);

    // reset mid-operation drops buffered results and pending bits
    wb_valid = 1'b1; wb_rd = 5'd9;
    div_valid = 1'b1; div_rd = 5'd14; div_data = 32'h0000_00E0;
    tick();
    div_valid = 1'b0;
    nrst = 1'b0;
    tick();
    chk("mid_rst_wr_en", {63'd0, wr_en}, 64'd0);
    chk("mid_rst_busy", {63'd0, src1_busy}, 64'd0);
    nrst = 1'b1; wb_valid = 1'b0;
    settle();
    chk("mid_rst_fifo_dropped", {63'd0, wr_en}, 64'd0);
    chk("mid_rst_sb_dropped", {63'd0, src1_busy}, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_writeback.md
# rf_writeback

Write-side controller for the 32x32 integer register file of the pipelined RV32IMC core. Merges the in-order pipeline writeback stream with out-of-order results from the multicycle divide unit onto the register file's single write port (wr_en / dest_addr / wr_data). Keeps a per-register pending scoreboard for issued divides and reports busy/forwarding status for the decode-stage read addresses. Pipeline writeback always wins the port. Divider results are buffered in a small FIFO and drained in idle cycles, with a starvation guard.

## Interface
- DEPTH, 2: divider result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: consecutive blocked cycles with a non-empty FIFO before stall_req asserts.

- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- wb_valid  in  1  pipeline writeback valid; cannot be back-pressured except via stall_req.
- wb_rd  in  5  pipeline destination register.
- wb_data  in  32  pipeline result.
- div_issue  in  1  divide/remainder issued this cycle.
- div_issue_rd  in  5  destination of the issued divide.
- div_valid  in  1  divider result valid.
- div_rd  in  5  divider result destination.
- div_data  in  32  divider result.
- div_ready  out  1  FIFO can accept; equals !full.
- src1_addr, src2_addr  in  5  decode-stage read addresses.
- src1_busy, src2_busy  out  1  address has a divide result not yet forwarded or written.
- stall_req  out  1  the pipeline must hold wb_valid low in the following cycle.
- wr_en  out  1  register file write enable.
- dest_addr  out  5  register file write address.
- wr_data  out  32  register file write data.

## Operation
- Port select, combinational: if wb_valid && wb_rd≠0, drive the pipeline write. Otherwise, if the FIFO is non-empty, drive the FIFO head and pop at the edge. Otherwise wr_en=0.
- Writes to x0 never assert wr_en. A pipeline writeback to x0 leaves the port free for the FIFO.
- FIFO push on div_valid && div_ready. An entry with div_rd=0 is accepted and discarded, with no push.
- When full, div_ready=0, even if a pop occurs that cycle. Push and pop in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
- Scoreboard, 32 bits, bit 0 tied to 0:
  - Bit is set on div_issue with div_issue_rd≠0.
  - Bit is cleared on the edge that writes a FIFO entry to the register file.
  - Same-cycle set and clear of one register: set wins.
- srcN_busy = scoreboard[srcN_addr]. Refined by the configuration macro below.
- Starvation counter, 0..STARVE_LIMIT:
  - Increments each cycle the FIFO is non-empty and the port is taken by the pipeline.
  - Resets to 0 on any FIFO pop or when the FIFO is empty.
  - stall_req = (counter == STARVE_LIMIT).
  - The pipeline guarantees wb_valid=0 in the cycle after stall_req. The FIFO pops in that cycle and the counter clears.
- Pipeline writes to a register whose scoreboard bit is set are prevented upstream by busy stalls. This block performs no write-after-write check.

## Timing
- Pipeline writeback to wr_en: 0 cycles (combinational). Register file updates at the same edge.
- Divider accept to register file write: at least 1 cycle. The entry accepted at edge N can be written during cycle N+1 at the earliest.
- Worst-case divider latency through the FIFO: bounded by DEPTH×(STARVE_LIMIT+2) cycles.
- Reset values, applied while nrst is low:
  - FIFO empty; div_ready=1.
  - scoreboard=0; src1_busy=src2_busy=0.
  - counter=0; stall_req=0.
  - wr_en=0, dest_addr=0, wr_data=0. These are forced 0 regardless of wb_valid.
- Reset mid-operation drops all buffered divider results and pending bits.

## Configuration
- RF_WB_BYPASS_EN defined:
  - Adds outputs fwd1_valid, fwd2_valid (1 bit) and fwd1_data, fwd2_data (32 bits).
  - fwdN_valid=1 when wr_en && dest_addr==srcN_addr && srcN_addr≠0; fwdN_data=wr_data.
  - srcN_busy is deasserted in the cycle its pending divide result is on the write port.
  - This closes the same-edge read-old-value window of the register file.
- Undefined:
  - The fwd ports are absent.
  - srcN_busy stays high through the write cycle and drops the cycle after.

## Test plan
- Reset:
  - Stimulus: nrst low 2 cycles with wb_valid=1, wb_rd=5.
  - Required: wr_en=0, div_ready=1, stall_req=0, all busy 0.
- Idle drain:
  - Stimulus: div_issue rd=7; 10 cycles later div_valid rd=7, data=0x0000_002A; wb_valid=0.
  - Required: src1_busy(7)=1 from the issue edge. Next cycle wr_en=1, dest_addr=7, wr_data=0x2A. busy(7)=0 after that edge, or during the write cycle with bypass.
- Priority and starvation:
  - Stimulus: FIFO holds rd=3; wb_valid=1 continuously (rd=9).
  - Required: pipeline writes for 4 cycles, stall_req=1 on the 5th. With wb_valid=0 the next cycle, dest_addr=3 is written and the counter clears.
- Full back-pressure:
  - Stimulus: push 2 results while wb_valid=1.
  - Required: div_ready=0. A third div_valid is held until the first pop plus one edge.
- x0 handling:
  - Stimulus: wb_valid with wb_rd=0 while the FIFO is non-empty; div result with div_rd=0.
  - Required: the FIFO head is written that cycle; the rd=0 result is discarded and never asserts wr_en.
- Scoreboard race:
  - Stimulus: div_issue rd=4 in the same cycle the FIFO writes rd=4.
  - Required: scoreboard bit 4 remains set.
